// File: rtl/alu_issue_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_pkg
// Shared definitions for the ID/EX ALU issue stage: ALUCtl encodings, MIPS
// opcode/funct values, instruction field slices and immediate extenders.
// ---------------------------------------------------------------------------
package alu_issue_stage_pkg;

  // ALUCtl encodings understood by the EX-stage ALU
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SLL = 5'b10000;
  localparam logic [4:0] ALU_SRL = 5'b11000;
  localparam logic [4:0] ALU_SRA = 5'b11001;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Shift amount fed to the ALU for LUI (imm << 16)
  localparam logic [31:0] LUI_SHAMT = 32'd16;

  function automatic logic [5:0] f_op(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] instr);
    return instr[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

  function automatic logic [31:0] sext16(input logic [31:0] instr);
    return {{16{instr[15]}}, instr[15:0]};
  endfunction

  function automatic logic [31:0] zext16(input logic [31:0] instr);
    return {16'h0000, instr[15:0]};
  endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_decode
// Purely combinational MIPS decode into ALU controls and operands.
// Ports:
//   i_instr    32  instruction word
//   i_rs_data  32  GPR[rs] (forwarded)
//   i_rt_data  32  GPR[rt] (forwarded)
//   o_ctl       5  ALUCtl
//   o_sign      1  signed compare (SLT/SLTI only)
//   o_in1      32  ALU in1 (shift amount for shifts)
//   o_in2      32  ALU in2
//   o_wr_en     1  register-file write enable
//   o_dst       5  destination register
//   o_illegal   1  opcode/funct not in the decode table
// ---------------------------------------------------------------------------
module alu_issue_stage_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output logic [4:0]  o_ctl,
  output logic        o_sign,
  output logic [31:0] o_in1,
  output logic [31:0] o_in2,
  output logic        o_wr_en,
  output logic [4:0]  o_dst,
  output logic        o_illegal
);

  logic [4:0]  w_ctl;
  logic        w_sign;
  logic [31:0] w_in1;
  logic [31:0] w_in2;
  logic        w_wr_en;
  logic [4:0]  w_dst;
  logic        w_legal;
  // The rs field is never decoded: its value arrives already read as i_rs_data.
  logic        w_unused_rs;

  assign w_unused_rs = ^i_instr[25:21];

  // Raw table decode, before illegal squashing and $0 write suppression
  always_comb begin
    w_ctl   = ALU_AND;
    w_sign  = 1'b0;
    w_in1   = i_rs_data;
    w_in2   = i_rt_data;
    w_wr_en = 1'b1;
    w_dst   = f_rt(i_instr);
    w_legal = 1'b1;
    case (f_op(i_instr))
      OP_RTYPE: begin
        w_dst = f_rd(i_instr);
        case (f_funct(i_instr))
          FN_ADD, FN_ADDU: w_ctl = ALU_ADD;
          FN_SUB, FN_SUBU: w_ctl = ALU_SUB;
          FN_AND:          w_ctl = ALU_AND;
          FN_OR:           w_ctl = ALU_OR;
          FN_XOR:          w_ctl = ALU_XOR;
          FN_NOR:          w_ctl = ALU_NOR;
          FN_SLT:          begin w_ctl = ALU_SLT; w_sign = 1'b1; end
          FN_SLTU:         w_ctl = ALU_SLT;
          FN_SLL:          begin w_ctl = ALU_SLL; w_in1 = {27'd0, f_shamt(i_instr)}; end
          FN_SRL:          begin w_ctl = ALU_SRL; w_in1 = {27'd0, f_shamt(i_instr)}; end
          FN_SRA:          begin w_ctl = ALU_SRA; w_in1 = {27'd0, f_shamt(i_instr)}; end
          FN_SLLV:         w_ctl = ALU_SLL;
          FN_SRLV:         w_ctl = ALU_SRL;
          FN_SRAV:         w_ctl = ALU_SRA;
          default:         w_legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin w_ctl = ALU_ADD; w_in2 = sext16(i_instr); end
      OP_SLTI:  begin w_ctl = ALU_SLT; w_sign = 1'b1; w_in2 = sext16(i_instr); end
      OP_SLTIU: begin w_ctl = ALU_SLT; w_in2 = sext16(i_instr); end
      OP_ANDI:  begin w_ctl = ALU_AND; w_in2 = zext16(i_instr); end
      OP_ORI:   begin w_ctl = ALU_OR;  w_in2 = zext16(i_instr); end
      OP_XORI:  begin w_ctl = ALU_XOR; w_in2 = zext16(i_instr); end
      OP_LUI:   begin w_ctl = ALU_SLL; w_in1 = LUI_SHAMT; w_in2 = zext16(i_instr); end
      OP_SW: begin
        w_ctl   = ALU_ADD;
        w_in2   = sext16(i_instr);
        w_wr_en = 1'b0;
        w_dst   = 5'd0;
      end
      OP_BEQ, OP_BNE: begin
        w_ctl   = ALU_SUB;
        w_wr_en = 1'b0;
        w_dst   = 5'd0;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal instructions present an all-zero payload; writes to $0 are dropped
  always_comb begin
    o_illegal = ~w_legal;
    if (w_legal) begin
      o_ctl   = w_ctl;
      o_sign  = w_sign;
      o_in1   = w_in1;
      o_in2   = w_in2;
      o_dst   = w_dst;
      o_wr_en = w_wr_en & (w_dst != 5'd0);
    end else begin
      o_ctl   = 5'd0;
      o_sign  = 1'b0;
      o_in1   = 32'd0;
      o_in2   = 32'd0;
      o_dst   = 5'd0;
      o_wr_en = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID/EX pipeline register feeding the ALU: decodes the ID instruction and
// registers controls/operands with stall/flush handling and an issue counter.
// Ports:
//   clk, reset (sync, active-high)
//   id_valid/id_ready          ID handshake (id_ready combinational)
//   id_instr/id_rs_data/id_rt_data  instruction and forwarded operands
//   ex_stall/ex_flush          EX hold / kill
//   ex_valid, ex_alu_ctl, ex_alu_sign, ex_in1, ex_in2,
//   ex_wr_en, ex_wr_dst, ex_illegal  registered EX payload
//   issue_cnt [CNT_W]          instructions loaded into EX (wraps)
// ---------------------------------------------------------------------------
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic             ex_stall,
  input  logic             ex_flush,
  output logic             ex_valid,
  output logic [4:0]       ex_alu_ctl,
  output logic             ex_alu_sign,
  output logic [31:0]      ex_in1,
  output logic [31:0]      ex_in2,
  output logic             ex_wr_en,
  output logic [4:0]       ex_wr_dst,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] issue_cnt
);

  logic [4:0]       w_ctl;
  logic             w_sign;
  logic [31:0]      w_in1;
  logic [31:0]      w_in2;
  logic             w_wr_en;
  logic [4:0]       w_dst;
  logic             w_illegal;
  logic             w_hold;

  logic             r_valid;
  logic [4:0]       r_ctl;
  logic             r_sign;
  logic [31:0]      r_in1;
  logic [31:0]      r_in2;
  logic             r_wr_en;
  logic [4:0]       r_dst;
  logic             r_illegal;
  logic [CNT_W-1:0] r_issue_cnt;

  alu_issue_stage_decode u_decode (
    .i_instr   (id_instr),
    .i_rs_data (id_rs_data),
    .i_rt_data (id_rt_data),
    .o_ctl     (w_ctl),
    .o_sign    (w_sign),
    .o_in1     (w_in1),
    .o_in2     (w_in2),
    .o_wr_en   (w_wr_en),
    .o_dst     (w_dst),
    .o_illegal (w_illegal)
  );

  // A stall only holds when there is something live to hold; otherwise it is a bubble.
  assign w_hold   = ex_stall & r_valid;
  assign id_ready = ~w_hold;

  // ID/EX register: reset > flush > hold > load
  always_ff @(posedge clk) begin
    if (reset || ex_flush) begin
      r_valid   <= 1'b0;
      r_ctl     <= 5'd0;
      r_sign    <= 1'b0;
      r_in1     <= 32'd0;
      r_in2     <= 32'd0;
      r_wr_en   <= 1'b0;
      r_dst     <= 5'd0;
      r_illegal <= 1'b0;
    end else if (w_hold) begin
      r_valid   <= r_valid;
    end else if (id_valid) begin
      r_valid   <= 1'b1;
      r_ctl     <= w_ctl;
      r_sign    <= w_sign;
      r_in1     <= w_in1;
      r_in2     <= w_in2;
      r_wr_en   <= w_wr_en;
      r_dst     <= w_dst;
      r_illegal <= w_illegal;
    end else begin
      r_valid   <= 1'b0;
      r_ctl     <= 5'd0;
      r_sign    <= 1'b0;
      r_in1     <= 32'd0;
      r_in2     <= 32'd0;
      r_wr_en   <= 1'b0;
      r_dst     <= 5'd0;
      r_illegal <= 1'b0;
    end
  end

  // Issue counter: counts only real loads of a valid instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issue_cnt <= '0;
    end else if (!ex_flush && !w_hold && id_valid) begin
      r_issue_cnt <= r_issue_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_issue_cnt <= r_issue_cnt;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_alu_ctl  = r_ctl;
  assign ex_alu_sign = r_sign;
  assign ex_in1      = r_in1;
  assign ex_in2      = r_in2;
  assign ex_wr_en    = r_wr_en;
  assign ex_wr_dst   = r_dst;
  assign ex_illegal  = r_illegal;
  assign issue_cnt   = r_issue_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Self-checking bench: directed cases plus randomized traffic against a
// behavioural model of the ID/EX stage (decode table + pipeline rules).
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int CNT_W = 4;

  // ALUCtl values as listed for the ALU
  localparam logic [4:0] C_AND = 5'b00000, C_OR  = 5'b00001, C_ADD = 5'b00010,
                         C_SUB = 5'b00110, C_SLT = 5'b00111, C_NOR = 5'b01100,
                         C_XOR = 5'b01101, C_SLL = 5'b10000, C_SRL = 5'b11000,
                         C_SRA = 5'b11001;

  typedef struct packed {
    logic [4:0]  ctl;
    logic        sign;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        wr;
    logic [4:0]  dst;
    logic        ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset, id_valid, id_ready, ex_stall, ex_flush;
  logic [31:0]      id_instr, id_rs_data, id_rt_data;
  logic             ex_valid, ex_alu_sign, ex_wr_en, ex_illegal;
  logic [4:0]       ex_alu_ctl, ex_wr_dst;
  logic [31:0]      ex_in1, ex_in2;
  logic [CNT_W-1:0] issue_cnt;

  // model state
  logic             m_valid;
  exp_t             m_pay;
  logic [CNT_W-1:0] m_cnt;

  int n_checks;
  int n_errors;

  always #5 clk = ~clk;

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .ex_valid(ex_valid),
    .ex_alu_ctl(ex_alu_ctl), .ex_alu_sign(ex_alu_sign), .ex_in1(ex_in1),
    .ex_in2(ex_in2), .ex_wr_en(ex_wr_en), .ex_wr_dst(ex_wr_dst),
    .ex_illegal(ex_illegal), .issue_cnt(issue_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set table
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0] op, fn;
    logic [31:0] sx, zx, sh;
    logic ok;
    op = ins[31:26];
    fn = ins[5:0];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    sh = {27'd0, ins[10:6]};
    ok = 1'b1;
    e = '0;
    e.in1 = rs;
    e.wr = 1'b1;
    e.dst = ins[20:16];
    if (op == 6'h00) begin
      e.in2 = rt;
      e.dst = ins[15:11];
      if (fn == 6'h20 || fn == 6'h21) e.ctl = C_ADD;
      else if (fn == 6'h22 || fn == 6'h23) e.ctl = C_SUB;
      else if (fn == 6'h24) e.ctl = C_AND;
      else if (fn == 6'h25) e.ctl = C_OR;
      else if (fn == 6'h26) e.ctl = C_XOR;
      else if (fn == 6'h27) e.ctl = C_NOR;
      else if (fn == 6'h2A) begin e.ctl = C_SLT; e.sign = 1'b1; end
      else if (fn == 6'h2B) e.ctl = C_SLT;
      else if (fn == 6'h00) begin e.ctl = C_SLL; e.in1 = sh; end
      else if (fn == 6'h02) begin e.ctl = C_SRL; e.in1 = sh; end
      else if (fn == 6'h03) begin e.ctl = C_SRA; e.in1 = sh; end
      else if (fn == 6'h04) e.ctl = C_SLL;
      else if (fn == 6'h06) e.ctl = C_SRL;
      else if (fn == 6'h07) e.ctl = C_SRA;
      else ok = 1'b0;
    end
    else if (op == 6'h08 || op == 6'h09 || op == 6'h23) begin e.ctl = C_ADD; e.in2 = sx; end
    else if (op == 6'h0A) begin e.ctl = C_SLT; e.sign = 1'b1; e.in2 = sx; end
    else if (op == 6'h0B) begin e.ctl = C_SLT; e.in2 = sx; end
    else if (op == 6'h0C) begin e.ctl = C_AND; e.in2 = zx; end
    else if (op == 6'h0D) begin e.ctl = C_OR;  e.in2 = zx; end
    else if (op == 6'h0E) begin e.ctl = C_XOR; e.in2 = zx; end
    else if (op == 6'h0F) begin e.ctl = C_SLL; e.in1 = 32'd16; e.in2 = zx; end
    else if (op == 6'h2B) begin e.ctl = C_ADD; e.in2 = sx; e.wr = 1'b0; e.dst = 5'd0; end
    else if (op == 6'h04 || op == 6'h05) begin e.ctl = C_SUB; e.in2 = rt; e.wr = 1'b0; e.dst = 5'd0; end
    else ok = 1'b0;
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
    end
    if (e.dst == 5'd0) e.wr = 1'b0;
    return e;
  endfunction

  // Random instruction biased toward the decode table
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0] op, fn;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0, 1, 2: op = 6'h00;
      3: op = 6'h08;  4: op = 6'h09;  5: op = 6'h0A;  6: op = 6'h0B;
      7: op = 6'h0C;  8: op = 6'h0D;  9: op = 6'h0E;  10: op = 6'h0F;
      11: op = 6'h23; 12: op = 6'h2B; 13: op = 6'h04; 14: op = 6'h05;
      default: op = 6'($urandom);
    endcase
    if (op == 6'h00) begin
      k = $urandom_range(0, 16);
      case (k)
        0: fn = 6'h20; 1: fn = 6'h21; 2: fn = 6'h22; 3: fn = 6'h23;
        4: fn = 6'h24; 5: fn = 6'h25; 6: fn = 6'h26; 7: fn = 6'h27;
        8: fn = 6'h2A; 9: fn = 6'h2B; 10: fn = 6'h00; 11: fn = 6'h02;
        12: fn = 6'h03; 13: fn = 6'h04; 14: fn = 6'h06; 15: fn = 6'h07;
        default: fn = 6'($urandom);
      endcase
      r[5:0] = fn;
    end
    return {op, r[25:0]};
  endfunction

  task automatic check_all();
    check("ex_valid",    32'(ex_valid),    32'(m_valid));
    check("ex_alu_ctl",  32'(ex_alu_ctl),  32'(m_pay.ctl));
    check("ex_alu_sign", 32'(ex_alu_sign), 32'(m_pay.sign));
    check("ex_in1",      ex_in1,           m_pay.in1);
    check("ex_in2",      ex_in2,           m_pay.in2);
    check("ex_wr_en",    32'(ex_wr_en),    32'(m_pay.wr));
    check("ex_wr_dst",   32'(ex_wr_dst),   32'(m_pay.dst));
    check("ex_illegal",  32'(ex_illegal),  32'(m_pay.ill));
    check("issue_cnt",   32'(issue_cnt),   32'(m_cnt));
  endtask

  // One clock: drive inputs, check id_ready, clock, advance model, check outputs
  task automatic step(input logic rst, input logic v, input logic [31:0] ins,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic st, input logic fl);
    reset = rst; id_valid = v; id_instr = ins; id_rs_data = a; id_rt_data = b;
    ex_stall = st; ex_flush = fl;
    #1;
    check("id_ready", 32'(id_ready), 32'(!(m_valid && st)));
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_pay = '0; m_cnt = '0;
    end else if (fl) begin
      m_valid = 1'b0; m_pay = '0;
    end else if (!(st && m_valid)) begin
      m_valid = v;
      m_pay = v ? ref_decode(ins, a, b) : '0;
      if (v) m_cnt = m_cnt + 1'b1;
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [CNT_W-1:0] saved_cnt;
    int guard;
    n_checks = 0; n_errors = 0;
    m_valid = 1'b0; m_pay = '0; m_cnt = '0;
    reset = 1'b1; id_valid = 1'b0; id_instr = 32'd0; id_rs_data = 32'd0;
    id_rt_data = 32'd0; ex_stall = 1'b0; ex_flush = 1'b0;

    // reset with random ID activity
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, rand_instr(), $urandom, $urandom, 1'($urandom), 1'b0);
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_cnt",   32'(issue_cnt), 32'd0);
    check("rst_in2",   ex_in2, 32'd0);

    // ADDI $t0,$t1,-1
    step(1'b0, 1'b1, 32'h2128FFFF, 32'd5, 32'h0, 1'b0, 1'b0);
    check("addi_ctl", 32'(ex_alu_ctl), 32'd2);
    check("addi_in1", ex_in1, 32'd5);
    check("addi_in2", ex_in2, 32'hFFFFFFFF);
    check("addi_dst", 32'(ex_wr_dst), 32'd8);
    check("addi_wr",  32'(ex_wr_en), 32'd1);

    // SRA $2,$3,4
    step(1'b0, 1'b1, 32'h00031103, $urandom, 32'h80000000, 1'b0, 1'b0);
    check("sra_ctl", 32'(ex_alu_ctl), 32'h19);
    check("sra_in1", ex_in1, 32'd4);
    check("sra_in2", ex_in2, 32'h80000000);

    // LUI $1,0x1234
    step(1'b0, 1'b1, 32'h3C011234, $urandom, $urandom, 1'b0, 1'b0);
    check("lui_ctl", 32'(ex_alu_ctl), 32'h10);
    check("lui_in1", ex_in1, 32'd16);
    check("lui_in2", ex_in2, 32'h00001234);

    // SLTIU $2,$1,5
    step(1'b0, 1'b1, 32'h2C220005, 32'd9, $urandom, 1'b0, 1'b0);
    check("sltiu_ctl",  32'(ex_alu_ctl), 32'h07);
    check("sltiu_sign", 32'(ex_alu_sign), 32'd0);

    // stall for 3 cycles while ID changes
    saved_cnt = issue_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, rand_instr(), $urandom, $urandom, 1'b1, 1'b0);
      check("stall_ctl", 32'(ex_alu_ctl), 32'h07);
      check("stall_cnt", 32'(issue_cnt), 32'(saved_cnt));
    end
    check("stall_ready", 32'(id_ready), 32'd0);

    // flush beats stall and a valid ID
    step(1'b0, 1'b1, rand_instr(), $urandom, $urandom, 1'b1, 1'b1);
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_in1",   ex_in1, 32'd0);
    check("flush_cnt",   32'(issue_cnt), 32'(saved_cnt));

    // illegal opcode 0x3F
    step(1'b0, 1'b1, {6'h3F, 26'($urandom)}, $urandom, $urandom, 1'b0, 1'b0);
    check("ill_flag", 32'(ex_illegal), 32'd1);
    check("ill_wr",   32'(ex_wr_en), 32'd0);

    // run the counter up to all-ones, then wrap
    guard = 0;
    while (m_cnt != 4'hF && guard < 20) begin
      step(1'b0, 1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b0);
      guard++;
    end
    check("cnt_top", 32'(issue_cnt), 32'hF);
    step(1'b0, 1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b0);
    check("cnt_wrap", 32'(issue_cnt), 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
           $urandom, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
